// File: rtl/i_sram_like_if_pkg.sv
// Shared types and constants for the fetch-side sram-like bridge.
// Holds the FSM state encoding and the fixed bus transfer size.
package i_sram_like_if_pkg;

    localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DISCARD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/i_sram_like_if.sv
// Bridges the single-cycle fetch port onto the sram-like instruction bus, one
// req/addr_ok/data_ok transaction per fetch, holding the word until the pipeline advances.
module i_sram_like_if
    import i_sram_like_if_pkg::*;
#(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   RST_INST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_inst_en,
    input  logic [AW-1:0] cpu_inst_addr,
    output logic [DW-1:0] cpu_inst_rdata,
    output logic          i_stall,
    input  logic          longest_stall,
    input  logic          flush,
    output logic          inst_req,
    output logic          inst_wr,
    output logic [1:0]    inst_size,
    output logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_wdata,
    input  logic          inst_addr_ok,
    input  logic          inst_data_ok,
    input  logic [DW-1:0] inst_rdata
);

    fetch_state_t  r_state;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_addr;
    logic          r_kill;

    fetch_state_t  w_nextState;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic          w_latchData;
    logic          w_latchAddr;
    logic          w_killSet;
    logic          w_killClr;
    logic          w_killed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_data  <= RST_INST;
            r_addr  <= '0;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_latchData) begin
                r_data <= inst_rdata;
            end
            if (w_latchAddr) begin
                r_addr <= cpu_inst_addr;
            end
            if (w_killClr) begin
                r_kill <= 1'b0;
            end else if (w_killSet) begin
                r_kill <= 1'b1;
            end
        end
    end

    // A flush seen while the address is still pending cannot abandon the
    // request, so it is remembered in r_kill and applied once addr_ok arrives.
    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_addr      = r_addr;
        w_latchData = 1'b0;
        w_latchAddr = 1'b0;
        w_killSet   = 1'b0;
        w_killClr   = 1'b0;
        w_killed    = r_kill | flush;
        case (r_state)
            ST_IDLE: begin
                w_req  = cpu_inst_en & ~flush;
                w_addr = cpu_inst_addr;
                if (w_req) begin
                    if (inst_addr_ok && inst_data_ok) begin
                        w_nextState = ST_DONE;
                        w_latchData = 1'b1;
                    end else if (inst_addr_ok) begin
                        w_nextState = ST_DATA;
                    end else begin
                        w_nextState = ST_ADDR;
                        w_latchAddr = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                w_req     = 1'b1;
                w_killSet = flush;
                if (inst_addr_ok) begin
                    w_killClr = 1'b1;
                    if (w_killed && inst_data_ok) begin
                        w_nextState = ST_IDLE;
                    end else if (w_killed) begin
                        w_nextState = ST_DISCARD;
                    end else if (inst_data_ok) begin
                        w_nextState = ST_DONE;
                        w_latchData = 1'b1;
                    end else begin
                        w_nextState = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (inst_data_ok && !flush) begin
                    w_nextState = ST_DONE;
                    w_latchData = 1'b1;
                end else if (inst_data_ok) begin
                    w_nextState = ST_IDLE;
                end else if (flush) begin
                    w_nextState = ST_DISCARD;
                end
            end
            ST_DONE: begin
                if (!longest_stall || flush) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                w_killClr = 1'b1;
                if (inst_data_ok) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign inst_req       = w_req;
    assign inst_addr      = w_addr;
    assign inst_wr        = 1'b0;
    assign inst_size      = SRAM_SIZE_WORD;
    assign inst_wdata     = '0;
    assign cpu_inst_rdata = r_data;
    assign i_stall        = cpu_inst_en & (r_state != ST_DONE);

endmodule
